seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
//   Serial 4-bit pattern detector with run control. A start request arms the
//   detector and latches the target pattern, overlap mode and window length.
//   Each valid bit is shifted into a 4-bit history (bit 3 oldest); a full
//   history equal to the pattern is a match, reported as a single-entry
//   valid/ready event carrying the index of the completing bit. A run ends on
//   stop or when the configured number of bits has been examined.
//
// Parameters
//   CNT_W        width of match counter, bit counter and event position
//   WIN_W        width of the detection-window length
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        arm request (honoured in IDLE/DONE, wins over stop)
//   stop         abort request (ARMED only, wins over bit_valid)
//   cfg_pattern  target pattern, bit 3 oldest        (latched on start)
//   cfg_overlap  1 = overlapping matches allowed     (latched on start)
//   cfg_window   bits to examine, 0 = unlimited      (latched on start)
//   bit_valid    bit_in valid this cycle
//   bit_in       serial data bit
//   evt_valid    match event pending
//   evt_ready    consumer accepts the pending event
//   evt_pos      0-based index since start of the bit completing the match
//   match_cnt    matches in the current run (saturating)
//   busy         state is ARMED
//   done         state is DONE
//   timeout      run ended by window expiry with no matches
//   evt_ovf      sticky: a match was lost while an event was pending
// ---------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_pos,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             evt_ovf
);

    localparam int unsigned CMP_W = (CNT_W > WIN_W) ? CNT_W : WIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [3:0]         pat_q,    pat_d;
    logic               ov_q,     ov_d;
    logic [WIN_W-1:0]   win_q,    win_d;
    logic [3:0]         hist_q,   hist_d;
    logic [2:0]         len_q,    len_d;
    logic [CNT_W-1:0]   bcnt_q,   bcnt_d;
    logic [CNT_W-1:0]   mcnt_q,   mcnt_d;
    logic               evv_q,    evv_d;
    logic [CNT_W-1:0]   evpos_q,  evpos_d;
    logic               to_q,     to_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // Candidate values for an accepted bit
    logic [3:0]         hist_n;
    logic [2:0]         len_n;
    logic [CNT_W-1:0]   bcnt_n;
    logic [CNT_W-1:0]   mcnt_n;
    logic               hit;
    logic               accept;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ov_d    = ov_q;
        win_d   = win_q;
        hist_d  = hist_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        evv_d   = evv_q;
        evpos_d = evpos_q;
        to_d    = to_q;
        ovf_d   = ovf_q;

        accept = evv_q & evt_ready;
        hist_n = {hist_q[2:0], bit_in};
        len_n  = (len_q == 3'd4) ? 3'd4 : len_q + 3'd1;
        bcnt_n = (bcnt_q == '1) ? bcnt_q : bcnt_q + CNT_W'(1);
        hit    = (len_n == 3'd4) && (hist_n == pat_q);
        mcnt_n = (hit && (mcnt_q != '1)) ? mcnt_q + CNT_W'(1) : mcnt_q;

        // Handshake runs in every state so a pending event can drain in DONE
        if (accept) begin
            evv_d = 1'b0;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ARMED;
                    pat_d   = cfg_pattern;
                    ov_d    = cfg_overlap;
                    win_d   = cfg_window;
                    hist_d  = '0;
                    len_d   = '0;
                    bcnt_d  = '0;
                    mcnt_d  = '0;
                    to_d    = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = DONE;
                end else if (bit_valid) begin
                    hist_d = hist_n;
                    len_d  = (hit && !ov_q) ? 3'd0 : len_n;
                    bcnt_d = bcnt_n;
                    mcnt_d = mcnt_n;
                    if (hit) begin
                        // Slot is free if empty or being drained this cycle
                        if (!evv_q || accept) begin
                            evv_d   = 1'b1;
                            evpos_d = bcnt_q;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if ((win_q != '0) && (CMP_W'(bcnt_n) == CMP_W'(win_q))) begin
                        state_d = DONE;
                        to_d    = (mcnt_n == '0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ARMED);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ov_q    <= 1'b0;
            win_q   <= '0;
            hist_q  <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            evv_q   <= 1'b0;
            evpos_q <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ov_q    <= ov_d;
            win_q   <= win_d;
            hist_q  <= hist_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
            evv_q   <= evv_d;
            evpos_q <= evpos_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign evt_valid = evv_q;
    assign evt_pos   = evpos_q;
    assign match_cnt = mcnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign evt_ovf   = ovf_q;

endmodule
